// File: rtl/addsub_pipe_pkg.sv
// Shared definitions for the pipelined add/sub: op encodings and
// segment/pipeline-depth helpers.
package addsub_pipe_pkg;

    localparam int unsigned DEF_W   = 16;
    localparam int unsigned DEF_SEG = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } op_e;

    function automatic int unsigned calc_nseg(input int unsigned w, input int unsigned seg);
        return w / seg;
    endfunction

    function automatic bit seg_legal(input int unsigned w, input int unsigned seg);
        return (seg != 0) && (seg <= w) && ((w % seg) == 0);
    endfunction

endpackage

// File: rtl/addsub_seg.sv
// Combinational SEG-bit carry-lookahead slice; every carry is a flat
// sum-of-products of generate/propagate terms and the slice carry-in.
module addsub_seg #(
    parameter int unsigned SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b2,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb_in
);

    logic [SEG-1:0] w_g;
    logic [SEG-1:0] w_p;
    logic [SEG:0]   w_c;

    assign w_g = a & b2;
    assign w_p = a ^ b2;

    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    always_comb begin
        logic acc;
        logic prop;
        acc    = 1'b0;
        prop   = 1'b0;
        w_c    = '0;
        w_c[0] = cin;
        for (int i = 0; i < int'(SEG); i++) begin
            acc  = w_g[i];
            prop = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prop & w_g[j]);
                prop = prop & w_p[j];
            end
            w_c[i+1] = acc | (prop & cin);
        end
    end

    assign sum      = w_p ^ w_c[SEG-1:0];
    assign cout     = w_c[SEG];
    assign c_msb_in = w_c[SEG-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement add/sub: one CLA segment per stage, registered
// inter-segment carry, valid/ready on both sides, ADC/SBC via stored carry.
module addsub_pipe
    import addsub_pipe_pkg::*;
#(
    parameter int unsigned W   = DEF_W,
    parameter int unsigned SEG = DEF_SEG
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] S,
    output logic         C,
    output logic         V,
    output logic         Z,
    output logic         N
);

    localparam int unsigned NSEG = calc_nseg(W, SEG);

    if (!seg_legal(W, SEG)) begin : g_bad_seg
        $error("addsub_pipe: W must be a non-zero multiple of SEG");
    end

    logic            w_en;
    logic            w_any_vld;
    logic            w_accept;
    logic            w_chain;
    logic            w_inv;
    logic            w_cin0;
    logic [W-1:0]    w_b2;

    // Per-stage inputs: remaining A/B2 right-aligned, partial sum filling from the top.
    logic [W-1:0]    w_a_in  [NSEG];
    logic [W-1:0]    w_b_in  [NSEG];
    logic [W-1:0]    w_s_in  [NSEG];
    logic            w_c_in  [NSEG];
    logic            w_v_in  [NSEG];
    logic [SEG-1:0]  w_sum   [NSEG];
    logic            w_cout  [NSEG];
    logic            w_cmsb  [NSEG];
    logic [W-1:0]    w_s_nxt [NSEG];

    logic [W-1:0]    r_a [NSEG];
    logic [W-1:0]    r_b [NSEG];
    logic [W-1:0]    r_s [NSEG];
    logic            r_c [NSEG];
    logic [NSEG-1:0] r_vld;
    logic            r_v;
    logic            r_z;
    logic            r_n;
    logic            r_cflag;

    assign w_any_vld = |r_vld;
    assign w_en      = !r_vld[NSEG-1] || out_ready;
    assign w_chain   = (op == OP_ADC) || (op == OP_SBC);
    assign w_inv     = (op == OP_SUB) || (op == OP_SBC);
    assign in_ready  = w_en && !(w_chain && w_any_vld);
    assign w_accept  = in_valid && in_ready;
    assign w_b2      = B ^ {W{w_inv}};
    assign w_cin0    = w_chain ? r_cflag : w_inv;

    for (genvar k = 0; k < int'(NSEG); k++) begin : g_stg
        if (k == 0) begin : g_first
            assign w_a_in[k] = A;
            assign w_b_in[k] = w_b2;
            assign w_s_in[k] = '0;
            assign w_c_in[k] = w_cin0;
            assign w_v_in[k] = w_accept;
        end else begin : g_next
            assign w_a_in[k] = r_a[k-1];
            assign w_b_in[k] = r_b[k-1];
            assign w_s_in[k] = r_s[k-1];
            assign w_c_in[k] = r_c[k-1];
            assign w_v_in[k] = r_vld[k-1];
        end

        addsub_seg #(.SEG(SEG)) u_seg (
            .a        (w_a_in[k][SEG-1:0]),
            .b2       (w_b_in[k][SEG-1:0]),
            .cin      (w_c_in[k]),
            .sum      (w_sum[k]),
            .cout     (w_cout[k]),
            .c_msb_in (w_cmsb[k])
        );

        assign w_s_nxt[k] = (w_s_in[k] >> SEG) | (W'(w_sum[k]) << (W - SEG));
    end

    // Whole pipeline advances or holds together; the last stage is the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NSEG; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
            end
            r_vld   <= '0;
            r_v     <= 1'b0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
            r_cflag <= 1'b0;
        end else if (w_en) begin
            for (int unsigned k = 0; k < NSEG; k++) begin
                r_a[k]   <= w_a_in[k] >> SEG;
                r_b[k]   <= w_b_in[k] >> SEG;
                r_s[k]   <= w_s_nxt[k];
                r_c[k]   <= w_cout[k];
                r_vld[k] <= w_v_in[k];
            end
            r_v <= w_cmsb[NSEG-1] ^ w_cout[NSEG-1];
            r_z <= (w_s_nxt[NSEG-1] == '0);
            r_n <= w_s_nxt[NSEG-1][W-1];
            if (w_v_in[NSEG-1]) begin
                r_cflag <= w_cout[NSEG-1];
            end
        end
    end

    assign out_valid = r_vld[NSEG-1];
    assign S         = r_s[NSEG-1];
    assign C         = r_c[NSEG-1];
    assign V         = r_v;
    assign Z         = r_z;
    assign N         = r_n;

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Pipelined, parametrised two's-complement adder/subtractor; the registered successor to our combinational CLA add/sub.
- Splits a W-bit operation into W/SEG carry-lookahead segments, one segment per pipeline stage, with the inter-segment carry registered between stages.
- Adds valid/ready handshaking on both sides, carry-chained ops (ADC/SBC) using a stored carry flag, and full C/V/Z/N flags.
- Used by the datapath wherever wide add/sub must meet timing.

Parameters:
- W, 16, operand/result width; must be a multiple of SEG, otherwise elaboration error.
- SEG, 4, segment width in bits; NSEG = W/SEG is the pipeline depth and latency.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand presented.
- in_ready  output  1  operand accepted when in_valid && in_ready.
- A  input  W  operand A.
- B  input  W  operand B.
- op  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBC.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- S  output  W  result.
- C  output  1  carry out of bit W-1 (for SUB/SBC: 1 = no borrow).
- V  output  1  signed overflow, carry into MSB XOR carry out of MSB.
- Z  output  1  S == 0.
- N  output  1  S[W-1].

Behaviour:
- Reset (synchronous, active-high): all stage valids 0, out_valid 0, S/C/V/Z/N 0, cflag 0. in_ready is 1 in the cycle after reset.
- Operand prep at acceptance:
  - B2 = B XOR {W{op[0]}}.
  - Carry-in cin = op[0] for ADD/SUB, cin = cflag for ADC/SBC.
- Stage k (1..NSEG) computes segment k-1 with G = A&B2 and P = A^B2 and its registered carry-in. It registers:
  - the completed low segments,
  - the carry out,
  - the carry into the segment's MSB (used only by the last stage),
  - the untouched upper A/B2 segments.
- The last stage register is the output. Flags are derived from it and are registered together with S.
- Latency: out_valid rises exactly NSEG cycles after acceptance when there is no stall. SEG = W gives latency 1.
- Throughput: one op per cycle while out_ready = 1.
- Stall: enable en = !out_valid || out_ready.
  - When en = 0, every stage holds its contents.
  - S and flags stay stable while out_valid && !out_ready.
  - Bubbles advance only together with the whole pipeline (global stall; no bubble collapsing).
- in_ready = en && !(op[1] && any stage valid, including the output stage).
  - ADC/SBC are interlocked until the pipeline is fully empty, so the op always uses the carry of the last produced result.
  - ADD/SUB are never interlocked beyond en.
- cflag is loaded with C when a result enters the output register.
- Ordering: results leave in acceptance order. There is no drop and no duplication.
- Simultaneous output handshake and input acceptance in the same cycle is legal and sustains full rate.
- rst mid-operation discards all in-flight ops. No partial result is ever presented.
- Arithmetic is modulo 2^W. C and V follow the combinational add/sub definitions exactly.

Decomposition:
- Shared package:
  - op encodings OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ADC = 2'b10, OP_SBC = 2'b11;
  - the NSEG derivation and the W % SEG legality check.
- Sub-module addsub_seg: combinational SEG-bit carry-lookahead slice.
  - Inputs: a, b2, cin.
  - Outputs: sum, cout, c_msb_in.
  - Instantiated once per stage via generate.

Test Plan (W=16, SEG=4, latency 4):
- ADD 0x7FFF + 0x0001, out_ready = 1 -> 4 cycles later out_valid = 1, S = 0x8000, C = 0, V = 1, N = 1, Z = 0.
- SUB 0x0005 - 0x0005 -> S = 0x0000, C = 1, Z = 1, V = 0, N = 0. SUB 0x0000 - 0x0001 -> S = 0xFFFF, C = 0, N = 1.
- Eight back-to-back ADDs (i + 0x0100) with out_ready = 1 -> one result per cycle, in order. Drop out_ready for 3 cycles mid-stream -> S held stable, in_ready = 0, no loss or duplication after release.
- ADD 0xFFFF + 0x0001 (S = 0, C = 1), then ADC 0x0000 + 0x0000 presented immediately -> in_ready = 0 until the pipeline drains; ADC result S = 0x0001, C = 0.
- SBC 0x0010 - 0x0001 with cflag = 0 -> S = 0x000E, C = 1. Same SBC with cflag = 1 -> S = 0x000F.
- Assert rst with 3 ops in flight -> the next cycle has out_valid = 0 and cflag = 0, and none of those results ever appear. in_ready = 1 the cycle after rst deasserts.
